// File: rtl/pushbutton_conditioner.sv
// Synchronizes, debounces and (optionally) latches board pushbuttons for the processor's IN port.
// Build with PB_STICKY_EN defined to hold short presses until the processor completes a read.
module pushbutton_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] buttons_raw,
    input  logic             read_strobe,
    output logic [WIDTH-1:0] pushbuttons,
    output logic             press_pending,
    output logic [WIDTH-1:0] stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Each bit counts how long sync2 has disagreed with its stable level.
    always_comb begin
        sync1_d  = buttons_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        rise     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    rise[i]     = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable = stable_q;

`ifdef PB_STICKY_EN
    logic [WIDTH-1:0] latched_q, latched_d;
    logic             rs_q, rs_d;
    logic             read_done;

    // A read completes on the strobe's falling edge; a same-edge new press survives it.
    always_comb begin
        rs_d      = read_strobe;
        read_done = rs_q & ~read_strobe;
        latched_d = (latched_q & ~{WIDTH{read_done}}) | rise;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            latched_q <= '0;
            rs_q      <= 1'b0;
        end else begin
            latched_q <= latched_d;
            rs_q      <= rs_d;
        end
    end

    assign pushbuttons   = latched_q | stable_q;
    assign press_pending = |latched_q;
`else
    logic             unused_read_strobe;
    logic [WIDTH-1:0] unused_rise;

    assign unused_read_strobe = read_strobe;
    assign unused_rise        = rise;
    assign pushbuttons        = stable_q;
    assign press_pending      = 1'b0;
`endif

endmodule
